// File: rtl/pedestrian_request_scheduler.sv
// Purpose: debounce two crossing buttons, latch presses, serve them round-robin to the light controller.
// Latency: raw press to serv_req_o is DEBOUNCE_CYCLES+3 edges when idle; MIN_GAP idle edges after serv_done_i.
// Backpressure: serv_req_o is held with a stable serv_id_o until serv_ack_i; new presses stay pending meanwhile.
module pedestrian_request_scheduler #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int MIN_GAP         = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic botao_A_i,
    input  logic botao_B_i,
    input  logic serv_ack_i,
    input  logic serv_done_i,
    output logic serv_req_o,
    output logic serv_id_o,
    output logic pend_A_o,
    output logic pend_B_o,
    output logic busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP - 1);

    // Index 0 is crossing A, index 1 is crossing B throughout.
    logic [1:0] btn;
    logic [1:0] rise;
    assign btn = {botao_B_i, botao_A_i};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic             s1_q, s2_q;
        logic             db_q, db_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Accept a new level only once it has differed from db for DEBOUNCE_CYCLES edges in a row.
        always_comb begin
            db_d  = db_q;
            cnt_d = '0;
            if (s2_q != db_q) begin
                if (cnt_q == DEB_LAST) begin
                    db_d = s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Two-flop synchronizer followed by the debounce state.
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                db_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                s1_q  <= btn[i];
                s2_q  <= s1_q;
                db_q  <= db_d;
                cnt_q <= cnt_d;
            end
        end

        // Only a debounced press (0->1) creates a request; releases are ignored.
        assign rise[i] = db_d & ~db_q;
    end

    logic [1:0]       state_q, state_d;
    logic [1:0]       pend_q, pend_d;
    logic             serv_id_q, serv_id_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             serv_req_q, busy_q;

    // Pending latch: accepted ack clears the served crossing, a fresh press sets it and wins a tie.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_REQ && serv_ack_i) begin
            pend_d[serv_id_q] = 1'b0;
        end
        pend_d = pend_d | rise;
    end

    // Service sequencer: pick a crossing, hold the request, wait for done, then enforce the gap.
    always_comb begin
        state_d   = state_q;
        serv_id_d = serv_id_q;
        last_d    = last_q;
        gap_d     = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    state_d   = ST_REQ;
                    // On a tie the crossing not served last goes first; otherwise the only one pending.
                    serv_id_d = (&pend_q) ? ~last_q : pend_q[1];
                end
            end
            ST_REQ: begin
                if (serv_ack_i) begin
                    last_d  = serv_id_q;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (serv_done_i) begin
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered status outputs; last_served resets to B so A wins the first tie.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            pend_q     <= 2'b00;
            serv_id_q  <= 1'b0;
            last_q     <= 1'b1;
            gap_q      <= '0;
            serv_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            serv_id_q  <= serv_id_d;
            last_q     <= last_d;
            gap_q      <= gap_d;
            serv_req_q <= (state_d == ST_REQ);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign serv_req_o = serv_req_q;
    assign serv_id_o  = serv_id_q;
    assign pend_A_o   = pend_q[0];
    assign pend_B_o   = pend_q[1];
    assign busy_o     = busy_q;

endmodule

// File: doc/pedestrian_request_scheduler.md
# pedestrian_request_scheduler

Front-end scheduler between the raw pedestrian push-buttons on GPIO and the intersection light controller. It synchronizes and debounces the two crossing buttons, latches each press as a pending request, and arbitrates between crossings A and B round-robin. It presents one service request at a time to the light controller over a req/ack/done handshake, and enforces a minimum gap between consecutive pedestrian phases.

## Interface
- DEBOUNCE_CYCLES, 8, consecutive stable cycles required to accept a button level change (>= 2)
- MIN_GAP, 16, idle cycles enforced after serv_done before the next request is issued (>= 1)
- CNT_W, 5, width of the debounce and gap counters; must hold max(DEBOUNCE_CYCLES, MIN_GAP)
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- botao_A  input  1  raw, asynchronous, active-high button, crossing A
- botao_B  input  1  raw, asynchronous, active-high button, crossing B
- serv_ack  input  1  light controller accepts the current request
- serv_done  input  1  light controller finished the pedestrian phase
- serv_req  output  1  request valid, registered
- serv_id  output  1  crossing requested: 0 = A, 1 = B
- pend_A  output  1  crossing A request pending, for the walk-request lamp
- pend_B  output  1  crossing B request pending
- busy  output  1  high whenever FSM is not IDLE

## Operation
- Per button: 2-flop synchronizer (s1, s2), debounced level db, counter cnt.
  - s2 == db: cnt <= 0.
  - s2 != db with cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0. Otherwise cnt++.
  - A level must differ from db for DEBOUNCE_CYCLES consecutive edges to be accepted; any return to db clears cnt.
- Pending latch: pend_x <= 1 on the edge where db_x goes 0->1. pend_x <= 0 on the edge where serv_ack is accepted for id x.
  - If set and clear coincide for the same x, set wins.
  - Releases (db falling) have no effect.
- FSM states: IDLE, REQ, SERVE, GAP.
  - IDLE: if pend_A | pend_B, go to REQ and load serv_id. If only one is pending, pick it. If both are pending, pick the crossing != last_served.
  - REQ: serv_req = 1; serv_id is held stable. On serv_ack = 1, clear pend[serv_id], set last_served <= serv_id, go to SERVE.
  - SERVE: wait for serv_done = 1, then load gap counter with MIN_GAP-1 and go to GAP.
  - GAP: decrement each cycle. At 0, go to IDLE.
- serv_ack is ignored outside REQ; serv_done is ignored outside SERVE.
- Presses during REQ, SERVE or GAP still set pending, including for the crossing currently served. That request is served in a later round.
- Reset values: serv_req 0, serv_id 0, pend_A 0, pend_B 0, busy 0, state IDLE, last_served = B (so A wins the first tie), all sync/db/cnt at 0.
  - Reset is asynchronous: asserting reset mid-operation forces these values immediately, regardless of clk.

## Timing
- serv_req = (state == REQ), busy = (state != IDLE); both are registered, with no combinational path from inputs.
- Press latency, raw rise just after edge 0: s2 = 1 at edge 2, db and pend_x rise at edge 2+DEBOUNCE_CYCLES, serv_req rises at edge 3+DEBOUNCE_CYCLES.
  - If FSM is not IDLE, serv_req rises one edge after the FSM returns to IDLE.
- Handshake: serv_req stays high until serv_ack is sampled high. serv_req falls on that same edge, and pend clears on that edge.
- serv_done sampled at edge N: GAP is entered at N. IDLE is reached at N+MIN_GAP. The earliest next serv_req is at N+MIN_GAP+1.
- serv_ack and serv_done are single-cycle or level inputs; only the first qualifying edge in the relevant state acts.

## Test plan
- Single press A (D=8, GAP=16): raw A high at cycle 0 for 20 cycles.
  - pend_A=1 at edge 10; serv_req=1, serv_id=0 at edge 11.
  - serv_ack at edge 14: serv_req=0 and pend_A=0 at edge 14.
  - serv_done at edge 20: busy=0 at edge 36.
- Bounce: botao_B toggles 3 high / 2 low for 30 cycles, then stays low.
  - pend_B stays 0, serv_req stays 0.
- Tie: A and B pressed in the same cycle from reset.
  - serv_id=0 first; after done+gap, serv_id=1.
  - Repeat the tie: serv_id=0 again, alternating by last_served.
- Re-press during service: press A while in SERVE for A.
  - pend_A=1 again, and A is re-requested exactly MIN_GAP+1 edges after serv_done.
- Reset mid-SERVE: drive reset=0 between clock edges.
  - All outputs are 0 immediately.
  - After release, a serv_done pulse with no pending requests leaves busy=0.
- Spurious handshake: pulse serv_ack and serv_done in IDLE.
  - No state change, all outputs remain 0.
